// File: rtl/clk_en_gen.sv
// clk_en_gen: lock-qualified multi-channel clock-enable generator.
//
// A raw PLL lock flag is synchronised into refclk, then a small FSM
// (WAIT_LOCK -> SETTLE -> RUN) requires the lock to hold for SETTLE_CYCLES
// cycles before the generator runs. In RUN, each channel owns a phase
// accumulator. Every carry out of an accumulator becomes a one-cycle
// clock-enable pulse on ce[k]. The mean pulse rate is
// f_refclk * inc_r[k] / 2^ACC_W.
//
// Outside RUN, all accumulators are held at zero. This means that every
// entry into RUN starts the channels phase-aligned. A load of new increments
// during RUN re-aligns the channels in the same way.
//
// Optional feature (macro CLK_EN_GEN_DIV_OUT_EN): adds output clk_div, one
// bit per channel. Each bit toggles once per ce pulse, which produces a
// divided square wave. The bits are cleared whenever the accumulators are
// cleared.
module clk_en_gen #(
  parameter int CHANNELS      = 2,
  parameter int ACC_W         = 32,
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic                      refclk,
  input  logic                      rst_n,
  input  logic                      pll_locked,
  input  logic [CHANNELS*ACC_W-1:0] inc,
  input  logic                      inc_load,
  output logic [CHANNELS-1:0]       ce,
`ifdef CLK_EN_GEN_DIV_OUT_EN
  output logic [CHANNELS-1:0]       clk_div,
`endif
  output logic                      locked
);

  localparam logic [1:0] WAIT_LOCK = 2'd0;
  localparam logic [1:0] SETTLE    = 2'd1;
  localparam logic [1:0] RUN       = 2'd2;

  // Settle counter is 16 bits, enough for the full SETTLE_CYCLES range.
  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);

  // Full-width add; the extra MSB is the carry that becomes the ce pulse.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                             input logic [ACC_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  logic              lk_sync_p0;
  logic              lk_p1;
  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [15:0]       settle_cnt;
  logic [15:0]       settle_cnt_nxt;
  logic              run_hold;
  logic              acc_clr;
  logic [ACC_W-1:0]  inc_r  [CHANNELS];
  logic [ACC_W-1:0]  acc_p0 [CHANNELS];
  logic [ACC_W:0]    sum_p0 [CHANNELS];
  logic [CHANNELS-1:0] ce_p1;

  // ---- stage: two-flop synchroniser for the asynchronous lock flag ----
  // Bring pll_locked into the refclk domain; only lk_p1 is used downstream.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lk_sync_p0 <= 1'b0;
      lk_p1      <= 1'b0;
    end else begin
      lk_sync_p0 <= pll_locked;
      lk_p1      <= lk_sync_p0;
    end
  end

  // Next-state and settle-count logic for the lock qualification FSM.
  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    case (state)
      WAIT_LOCK: begin
        if (lk_p1) begin
          state_nxt      = SETTLE;
          settle_cnt_nxt = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (!lk_p1) begin
          state_nxt = WAIT_LOCK;
        end else if (settle_cnt == 16'd0) begin
          state_nxt = RUN;
        end else begin
          settle_cnt_nxt = settle_cnt - 16'd1;
        end
      end
      RUN: begin
        if (!lk_p1) begin
          state_nxt = WAIT_LOCK;
        end
      end
      default: begin
        state_nxt = WAIT_LOCK;
      end
    endcase
  end

  // State register. locked is registered from the next state, so it is
  // high exactly in the cycles where state holds RUN.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_LOCK;
      settle_cnt <= 16'd0;
      locked     <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_cnt_nxt;
      locked     <= (state_nxt == RUN);
    end
  end

  // Accumulators advance only while the FSM stays in RUN. A load during RUN
  // re-aligns all channels by clearing them on the same edge.
  assign run_hold = (state == RUN) && lk_p1;
  assign acc_clr  = !run_hold || inc_load;

  // Per-channel sums of accumulator and shadow increment.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      sum_p0[k] = acc_add(acc_p0[k], inc_r[k]);
    end
  end

  // Shadow increment capture. This happens in any state, so rates can be
  // programmed before the lock is established.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CHANNELS; k++) begin
        inc_r[k] <= '0;
      end
    end else if (inc_load) begin
      for (int k = 0; k < CHANNELS; k++) begin
        inc_r[k] <= inc[k*ACC_W +: ACC_W];
      end
    end
  end

  // ---- stage: accumulate -> registered carry (ce) ----
  // Update the phase accumulators and register the carry as the ce pulse.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CHANNELS; k++) begin
        acc_p0[k] <= '0;
      end
      ce_p1 <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (acc_clr) begin
          acc_p0[k] <= '0;
          ce_p1[k]  <= 1'b0;
        end else begin
          acc_p0[k] <= sum_p0[k][ACC_W-1:0];
          ce_p1[k]  <= sum_p0[k][ACC_W];
        end
      end
    end
  end

  assign ce = ce_p1;

`ifdef CLK_EN_GEN_DIV_OUT_EN
  // ---- stage: ce -> divided clock ----
  // Each divided output toggles once per ce pulse. It restarts from 0
  // whenever the accumulators are cleared, so it stays aligned with them.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      clk_div <= '0;
    end else if (acc_clr) begin
      clk_div <= '0;
    end else begin
      clk_div <= clk_div ^ ce_p1;
    end
  end
`endif

endmodule

// File: doc/clk_en_gen.md
CLK_EN_GEN -- requirements
Module: clk_en_gen

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent clock-enable channels, legal range 1..8.
REQ-002 SHALL have parameter ACC_W, default 32: phase-accumulator width in bits, legal range 8..32.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 1024: number of refclk cycles lock must hold before `locked` asserts, legal range 1..65535.
REQ-004 SHALL have port refclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port pll_locked, input, 1 bit: raw PLL lock indication, asynchronous to refclk.
REQ-007 SHALL have port inc, input, CHANNELS*ACC_W bits: per-channel phase increment; channel k occupies bits [k*ACC_W +: ACC_W].
REQ-008 SHALL have port inc_load, input, 1 bit: single-cycle request to apply `inc`.
REQ-009 SHALL have port ce, output, CHANNELS bits: one-refclk-cycle clock-enable pulses, one bit per channel.
REQ-010 SHALL have port locked, output, 1 bit: high while the generator is in RUN.

Function
REQ-011 SHALL synchronise pll_locked through a 2-flop synchroniser; all lock decisions SHALL use the synchronised value (lk).
REQ-012 SHALL implement the states WAIT_LOCK, SETTLE and RUN.
REQ-013 WAIT_LOCK SHALL go to SETTLE when lk=1 and load the settle counter with SETTLE_CYCLES-1.
REQ-014 SETTLE SHALL decrement the settle counter each cycle; at count 0 with lk=1 it SHALL go to RUN.
REQ-015 In SETTLE, lk=0 SHALL return the block to WAIT_LOCK.
REQ-016 In RUN, lk=0 SHALL return the block to WAIT_LOCK on the next edge.
REQ-017 On entering RUN, all accumulators SHALL equal 0, so channels are phase-aligned.
REQ-018 locked SHALL be registered and equal 1 exactly in the cycles the state register holds RUN.
REQ-019 Each channel SHALL hold shadow increment inc_r[k], reset value 0.
REQ-020 On inc_load=1, all inc_r[k] SHALL capture `inc` in that cycle, in any state.
REQ-021 If inc_load=1 in RUN, all accumulators SHALL clear to 0 on the same edge, and ce SHALL be 0 on the following cycle (re-alignment).
REQ-022 In RUN with no load, each cycle SHALL compute {carry, acc} = acc + inc_r[k] as an ACC_W+1-bit sum; acc SHALL take the low ACC_W bits (modulo 2^ACC_W wrap).
REQ-023 ce[k] SHALL be registered and equal carry, so a pulse appears one cycle after the overflowing add; the mean rate is f_refclk*inc_r[k]/2^ACC_W.
REQ-024 inc_r[k]=0 SHALL never produce ce[k].
REQ-025 The maximum increment 2^ACC_W-1 SHALL produce ce[k] in every cycle except one in 2^ACC_W.
REQ-026 Outside RUN, ce SHALL be all-zero and accumulators SHALL be held at 0.

Reset
REQ-027 rst_n=0 SHALL asynchronously clear the synchroniser, set state to WAIT_LOCK, and clear the settle counter, all accumulators, all inc_r, ce and locked.
REQ-028 Reset deassertion SHALL be used as-is; the block's integrator supplies deassertion synchronised to refclk.
REQ-029 Reset asserted in RUN SHALL drop ce and locked to 0 immediately, without waiting for a clock edge.

Configuration
REQ-030 The macro CLK_EN_GEN_DIV_OUT_EN SHALL control an extra output port clk_div, CHANNELS bits wide.
REQ-031 With CLK_EN_GEN_DIV_OUT_EN defined, clk_div[k] SHALL toggle on each cycle in which ce[k]=1.
REQ-032 With CLK_EN_GEN_DIV_OUT_EN defined, clk_div SHALL reset to 0 and clear to 0 whenever the block is outside RUN or a re-alignment occurs.
REQ-033 Without CLK_EN_GEN_DIV_OUT_EN, the clk_div port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification (bench parameters: CHANNELS=2, ACC_W=8, SETTLE_CYCLES=4)
REQ-034 Bench SHALL cover lock-up: hold pll_locked=1 from reset release -> locked rises exactly 2 (sync) + 1 + 4 cycles after release, and ce=0 throughout.
REQ-035 Bench SHALL cover rates: inc0=0x40, inc1=0x80 loaded before lock -> in RUN, ce[0] pulses every 4 cycles and ce[1] every 2 cycles, first pulses aligned at cycles 4 and 2.
REQ-036 Bench SHALL cover a lock drop: pll_locked to 0 for 1 cycle in RUN -> locked falls 3 cycles later, ce=0, and the full SETTLE sequence repeats.
REQ-037 Bench SHALL cover a live reload: inc_load with inc0=0x55 mid-RUN -> accumulators 0 next cycle, ce[0] next pulse 4 cycles after reload (0x55*4=0x154 wraps), then the 0x55 cadence continues.
REQ-038 Bench SHALL cover boundary increments: inc0=0x00, inc1=0xFF -> ce[0] never asserts, ce[1] low exactly once per 256 cycles.
REQ-039 Bench SHALL cover asynchronous reset: rst_n low between clock edges in RUN -> ce and locked 0 before the next edge; with CLK_EN_GEN_DIV_OUT_EN defined, clk_div[1] has a period of 4 cycles when inc1=0x80.
